nyq_coeff_loader: RTL and testbench

Write-side initiator for the NYQ coefficient memory port. Accepts a stream of coefficient words from the host/config path over a valid/ready handshake and turns it into a sequence of single-cycle memory writes (write enable, address, data) on NYQ's parameter port, starting at a programmed base address. Sits between the configuration deserializer and NYQ. Reports completion, abort and error status back to the configuration controller.

---
 rtl/nyq_coeff_loader.sv | 113 +++++++++++
 tb/tb_nyq_coeff_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_coeff_loader.sv
// Write-side initiator for the NYQ coefficient memory: turns a valid/ready word
// stream into single-cycle writes starting at a programmed base address.
module nyq_coeff_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Start_SI,
    input  logic [ADDR_WIDTH-1:0] BaseAddr_DI,
    input  logic [ADDR_WIDTH:0]   Count_DI,
    input  logic                  Abort_SI,
    input  logic                  Coef_Valid_SI,
    input  logic [MEM_WIDTH-1:0]  Coef_In_DI,
    output logic                  Coef_Ready_SO,
    output logic                  WrEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic                  Err_SO
);

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    localparam logic [ADDR_WIDTH:0] LP_MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    // A request larger than the memory still fills it exactly once.
    function automatic logic [ADDR_WIDTH:0] f_clamp_count(input logic [ADDR_WIDTH:0] cnt);
        return (cnt > LP_MAX_CNT) ? LP_MAX_CNT : cnt;
    endfunction

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_rem;
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic [MEM_WIDTH-1:0]  r_data_out;
    logic                  r_done;
    logic                  r_err;

    logic w_ready;
    logic w_accept;
    logic w_last;

    assign w_ready  = (r_state == S_LOAD) && !Abort_SI;
    assign w_accept = Coef_Valid_SI && w_ready;
    assign w_last   = (r_rem == {{ADDR_WIDTH{1'b0}}, 1'b1});

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_wren     <= 1'b0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start_SI) begin
                        if (Count_DI == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err   <= (Count_DI > LP_MAX_CNT);
                            r_addr  <= BaseAddr_DI;
                            r_rem   <= f_clamp_count(Count_DI);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // A restart request mid-sequence is flagged but never resamples.
                    if (Start_SI) begin
                        r_err <= 1'b1;
                    end
                    if (Abort_SI) begin
                        r_rem   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_wren     <= 1'b1;
                        r_addr_out <= r_addr;
                        r_data_out <= Coef_In_DI;
                        r_addr     <= r_addr + 1'b1;
                        r_rem      <= r_rem - 1'b1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Coef_Ready_SO = w_ready;
    assign Busy_SO       = (r_state == S_LOAD);
    assign WrEn_SO       = r_wren;
    assign Addr_DO       = r_addr_out;
    assign PAR_Out_DO    = r_data_out;
    assign Done_SO       = r_done;
    assign Err_SO        = r_err;

endmodule

// File: tb/tb_nyq_coeff_loader.sv
// Directed self-checking bench for nyq_coeff_loader: reset, full fill, wrap,
// count edge cases, abort and restart-while-busy.
module tb_nyq_coeff_loader;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [5:0]  Base;
    logic [6:0]  Count;
    logic        Abort;
    logic        Valid;
    logic [23:0] Coef_In;
    logic        Coef_Ready_SO;
    logic        WrEn_SO;
    logic [5:0]  Addr_DO;
    logic [23:0] PAR_Out_DO;
    logic        Busy_SO;
    logic        Done_SO;
    logic        Err_SO;

    int n_chk  = 0;
    int n_pass = 0;

    // Capture of one load run
    logic [5:0]  wr_addr [0:127];
    logic [23:0] wr_data [0:127];
    int          wr_cyc  [0:127];
    logic        busy_c  [0:127];
    logic        ready_c [0:127];
    logic [23:0] mem     [0:63];
    int          nwr;
    int          done_cnt;
    int          done_cyc;
    int          err_cnt;
    int          err_cyc;
    logic        ready_abort;

    nyq_coeff_loader #(.ADDR_WIDTH(6), .MEM_WIDTH(24)) dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .Start_SI     (Start),
        .BaseAddr_DI  (Base),
        .Count_DI     (Count),
        .Abort_SI     (Abort),
        .Coef_Valid_SI(Valid),
        .Coef_In_DI   (Coef_In),
        .Coef_Ready_SO(Coef_Ready_SO),
        .WrEn_SO      (WrEn_SO),
        .Addr_DO      (Addr_DO),
        .PAR_Out_DO   (PAR_Out_DO),
        .Busy_SO      (Busy_SO),
        .Done_SO      (Done_SO),
        .Err_SO       (Err_SO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and capture only. mode 0: valid always high, mode 1: valid every other cycle.
    // Observation index c = 0 is the cycle right after the Start edge.
    task automatic run_load(input int base, input int count, input int mode,
                            input int abort_word, input int restart_cyc, input int ncyc);
        int sent;
        bit acc;
        bit aborted;
        nwr = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        ready_abort = 1'b1;
        sent = 0; aborted = 0;
        Start = 1'b1; Base = base[5:0]; Count = count[6:0];
        cyc();
        Start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            busy_c[c]  = Busy_SO;
            ready_c[c] = Coef_Ready_SO;
            if (WrEn_SO === 1'b1 && nwr < 128) begin
                wr_addr[nwr] = Addr_DO;
                wr_data[nwr] = PAR_Out_DO;
                wr_cyc[nwr]  = c;
                mem[Addr_DO] = PAR_Out_DO;
                nwr++;
            end
            if (Done_SO === 1'b1) begin done_cnt++; done_cyc = c; end
            if (Err_SO === 1'b1) begin err_cnt++; err_cyc = c; end
            Valid   = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            Coef_In = 24'h100000 + sent[23:0];
            if (abort_word >= 0 && !aborted && sent == abort_word && Valid) begin
                Abort = 1'b1; aborted = 1;
            end
            if (c == restart_cyc) begin Start = 1'b1; Base = 6'd20; Count = 7'd2; end
            #1;
            if (Abort) ready_abort = Coef_Ready_SO;
            acc = Valid && Coef_Ready_SO;
            cyc();
            if (acc) sent++;
            Abort = 1'b0; Start = 1'b0;
        end
        Valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (WrEn_SO !== 1'b0) $display("FAIL rst_wren: got %b want 0", WrEn_SO); else n_pass++;
        n_chk++; if (Addr_DO !== 6'd0) $display("FAIL rst_addr: got %0d want 0", Addr_DO); else n_pass++;
        n_chk++; if (PAR_Out_DO !== 24'd0) $display("FAIL rst_data: got %h want 0", PAR_Out_DO); else n_pass++;
        n_chk++; if (Busy_SO !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy_SO); else n_pass++;
        n_chk++; if (Coef_Ready_SO !== 1'b0) $display("FAIL rst_ready: got %b want 0", Coef_Ready_SO); else n_pass++;
        n_chk++; if ({Done_SO, Err_SO} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {Done_SO, Err_SO}); else n_pass++;
        rst = 1'b0;
        cyc();
        n_chk++; if (Busy_SO !== 1'b0) $display("FAIL idle_busy: got %b want 0", Busy_SO); else n_pass++;
        // Reset mid-load after 3 of 10 words
        Start = 1'b1; Base = 6'd0; Count = 7'd10;
        cyc();
        Start = 1'b0; Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Coef_In = 24'h100000 + i[23:0];
            cyc();
        end
        n_chk++; if (WrEn_SO !== 1'b1 || Addr_DO !== 6'd2 || PAR_Out_DO !== 24'h100002)
            $display("FAIL pre_rst_write: got en=%b addr=%0d data=%h want en=1 addr=2 data=100002", WrEn_SO, Addr_DO, PAR_Out_DO);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (WrEn_SO !== 1'b0 || Addr_DO !== 6'd0 || PAR_Out_DO !== 24'd0)
            $display("FAIL async_rst_write: got en=%b addr=%0d data=%h want all 0", WrEn_SO, Addr_DO, PAR_Out_DO);
        else n_pass++;
        n_chk++; if (Busy_SO !== 1'b0 || Coef_Ready_SO !== 1'b0 || Done_SO !== 1'b0 || Err_SO !== 1'b0)
            $display("FAIL async_rst_ctrl: got busy=%b rdy=%b done=%b err=%b want all 0", Busy_SO, Coef_Ready_SO, Done_SO, Err_SO);
        else n_pass++;
        cyc();
        rst = 1'b0;
        #1;
        n_chk++; if (Busy_SO !== 1'b0 || Coef_Ready_SO !== 1'b0)
            $display("FAIL post_rst_idle: got busy=%b rdy=%b want 0 0", Busy_SO, Coef_Ready_SO);
        else n_pass++;
        cyc();
        n_chk++; if (WrEn_SO !== 1'b0 || Busy_SO !== 1'b0)
            $display("FAIL post_rst_nowrite: got en=%b busy=%b want 0 0", WrEn_SO, Busy_SO);
        else n_pass++;
        Valid = 1'b0;
        cyc();
    endtask

    task automatic test_full_fill();
        logic [23:0] exp_d;
        for (int i = 0; i < 64; i++) mem[i] = 24'd0;
        run_load(0, 64, 0, -1, -1, 68);
        n_chk++; if (busy_c[0] !== 1'b1 || ready_c[0] !== 1'b1)
            $display("FAIL full_start: got busy=%b rdy=%b want 1 1", busy_c[0], ready_c[0]);
        else n_pass++;
        n_chk++; if (nwr !== 64) $display("FAIL full_nwr: got %0d want 64", nwr); else n_pass++;
        for (int i = 0; i < 64 && i < nwr; i++) begin
            exp_d = 24'h100000 + i[23:0];
            n_chk++; if (wr_addr[i] !== i[5:0] || wr_data[i] !== exp_d || wr_cyc[i] != i + 1)
                $display("FAIL full_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], i, exp_d, i + 1);
            else n_pass++;
        end
        n_chk++; if (done_cnt != 1 || done_cyc != 64)
            $display("FAIL full_done: got cnt=%0d cyc=%0d want 1 at 64", done_cnt, done_cyc);
        else n_pass++;
        n_chk++; if (busy_c[64] !== 1'b0 || ready_c[64] !== 1'b0)
            $display("FAIL full_end_idle: got busy=%b rdy=%b want 0 0", busy_c[64], ready_c[64]);
        else n_pass++;
        n_chk++; if (err_cnt != 0) $display("FAIL full_err: got %0d want 0", err_cnt); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            exp_d = 24'h100000 + i[23:0];
            n_chk++; if (mem[i] !== exp_d) $display("FAIL full_readback%0d: got %h want %h", i, mem[i], exp_d);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_stall();
        logic [5:0] exp_a;
        run_load(60, 8, 1, -1, -1, 20);
        n_chk++; if (nwr !== 8) $display("FAIL wrap_nwr: got %0d want 8", nwr); else n_pass++;
        for (int i = 0; i < 8 && i < nwr; i++) begin
            exp_a = 6'(60 + i);
            n_chk++; if (wr_addr[i] !== exp_a || wr_cyc[i] != 2 * i + 1)
                $display("FAIL wrap_write%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                         i, wr_addr[i], wr_cyc[i], exp_a, 2 * i + 1);
            else n_pass++;
        end
        n_chk++; if (done_cnt != 1 || done_cyc != 15)
            $display("FAIL wrap_done: got cnt=%0d cyc=%0d want 1 at 15", done_cnt, done_cyc);
        else n_pass++;
    endtask

    task automatic test_count_edges();
        run_load(5, 0, 0, -1, -1, 6);
        n_chk++; if (done_cnt != 1 || done_cyc != 0)
            $display("FAIL cnt0_done: got cnt=%0d cyc=%0d want 1 at 0", done_cnt, done_cyc);
        else n_pass++;
        n_chk++; if (nwr != 0 || busy_c[0] !== 1'b0 || err_cnt != 0)
            $display("FAIL cnt0_idle: got nwr=%0d busy=%b err=%0d want 0 0 0", nwr, busy_c[0], err_cnt);
        else n_pass++;
        run_load(0, 65, 0, -1, -1, 70);
        n_chk++; if (err_cnt != 1 || err_cyc != 0)
            $display("FAIL cnt65_err: got cnt=%0d cyc=%0d want 1 at 0", err_cnt, err_cyc);
        else n_pass++;
        n_chk++; if (nwr != 64) $display("FAIL cnt65_nwr: got %0d want 64", nwr); else n_pass++;
        n_chk++; if (wr_addr[0] !== 6'd0 || wr_addr[63] !== 6'd63 || done_cnt != 1 || done_cyc != 64)
            $display("FAIL cnt65_span: got first=%0d last=%0d done=%0d@%0d want 0 63 1@64",
                     wr_addr[0], wr_addr[63], done_cnt, done_cyc);
        else n_pass++;
    endtask

    task automatic test_abort();
        run_load(10, 10, 0, 4, -1, 14);
        n_chk++; if (nwr != 4) $display("FAIL abort_nwr: got %0d want 4", nwr); else n_pass++;
        n_chk++; if (wr_addr[0] !== 6'd10 || wr_addr[3] !== 6'd13 || wr_cyc[3] != 4)
            $display("FAIL abort_writes: got first=%0d last=%0d lastcyc=%0d want 10 13 4",
                     wr_addr[0], wr_addr[3], wr_cyc[3]);
        else n_pass++;
        n_chk++; if (ready_abort !== 1'b0) $display("FAIL abort_ready: got %b want 0", ready_abort); else n_pass++;
        n_chk++; if (busy_c[4] !== 1'b1 || busy_c[5] !== 1'b0)
            $display("FAIL abort_busy: got %b%b want 10", busy_c[4], busy_c[5]);
        else n_pass++;
        n_chk++; if (done_cnt != 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else n_pass++;
    endtask

    task automatic test_restart_busy();
        int hit20;
        run_load(30, 4, 0, -1, 1, 10);
        hit20 = 0;
        for (int i = 0; i < nwr; i++) if (wr_addr[i] === 6'd20) hit20++;
        n_chk++; if (err_cnt != 1 || err_cyc != 2)
            $display("FAIL restart_err: got cnt=%0d cyc=%0d want 1 at 2", err_cnt, err_cyc);
        else n_pass++;
        n_chk++; if (nwr != 4 || hit20 != 0 || wr_addr[0] !== 6'd30 || wr_addr[3] !== 6'd33)
            $display("FAIL restart_writes: got nwr=%0d hit20=%0d first=%0d last=%0d want 4 0 30 33",
                     nwr, hit20, wr_addr[0], wr_addr[3]);
        else n_pass++;
        n_chk++; if (done_cnt != 1 || done_cyc != 4)
            $display("FAIL restart_done: got cnt=%0d cyc=%0d want 1 at 4", done_cnt, done_cyc);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; Base = '0; Count = '0; Abort = 1'b0;
        Valid = 1'b0; Coef_In = '0;
        test_reset();
        test_full_fill();
        test_wrap_stall();
        test_count_edges();
        test_abort();
        test_restart_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
